seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 170 +++++++++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

    // Default operand width; the dividend is twice this wide.
    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Error results fill quotient/remainder with this bit (all ones).
    localparam logic ERR_QUOT_FILL_BIT = 1'b1;
    localparam logic ERR_REM_FILL_BIT  = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract D.
// Latency: combinational, no state.
// Backpressure: none; driven every cycle by the parent, used only in CALC.
//
// Ports:
//   r_in  [WIDTH:0]   partial remainder before the step
//   q_msb             next dividend bit, shifted into the remainder LSB
//   d     [WIDTH-1:0] divisor
//   r_out [WIDTH:0]   partial remainder after the step
//   q_bit             quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    // One extra bit of headroom so the shift never loses information before the compare.
    logic [WIDTH+1:0] shifted;

    assign shifted = {r_in, q_msb};

    // "trial non-negative" is the same as shifted >= D; keep the difference only then.
    assign q_bit = (shifted >= {2'b00, d});
    assign r_out = q_bit ? (WIDTH+1)'(shifted - {2'b00, d}) : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> quotient, remainder.
// Latency: out_valid rises after the WIDTH-th edge past accept (after the accept edge itself for errors with DIV_EARLY_EXIT_EN).
// Backpressure: in_ready low while busy (in_valid ignored); results held in DONE until out_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake; dividend [2*WIDTH-1:0], divisor [WIDTH-1:0]
//   out_valid/out_ready      result handshake; quotient, remainder [WIDTH-1:0]
//   err_dbz                  divisor was zero (quotient all ones, remainder = dividend low half)
//   err_ovf                  quotient would not fit in WIDTH bits (quotient, remainder all ones)
//
// Build option: define DIV_EARLY_EXIT_EN to skip the CALC phase for erroneous operations.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 err_dbz,
    output logic                 err_ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] QUOT_FILL = {WIDTH{ERR_QUOT_FILL_BIT}};
    localparam logic [WIDTH-1:0] REM_FILL  = {WIDTH{ERR_REM_FILL_BIT}};

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;         // partial remainder
    logic [WIDTH-1:0] q_q, q_d;         // dividend low bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] d_q, d_d;         // captured divisor
    logic [WIDTH-1:0] lo_q, lo_d;       // dividend low half, kept for the divide-by-zero remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   step_r;
    logic             step_qb;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] dvd_hi;
    logic             acc_dbz;
    logic             acc_ovf;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .r_in  (r_q),
        .q_msb (q_q[WIDTH-1]),
        .d     (d_q),
        .r_out (step_r),
        .q_bit (step_qb)
    );

    assign q_next  = {q_q[WIDTH-2:0], step_qb};
    assign dvd_hi  = dividend[2*WIDTH-1:WIDTH];
    assign acc_dbz = (divisor == '0);
    // High half >= divisor means the quotient needs more than WIDTH bits.
    assign acc_ovf = (divisor != '0) && (dvd_hi >= divisor);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d     = divisor;
                    r_d     = {1'b0, dvd_hi};
                    q_d     = dividend[WIDTH-1:0];
                    lo_d    = dividend[WIDTH-1:0];
                    cnt_d   = '0;
                    dbz_d   = acc_dbz;
                    ovf_d   = acc_ovf;
                    state_d = CALC;
`ifdef DIV_EARLY_EXIT_EN
                    if (acc_dbz || acc_ovf) begin
                        state_d = DONE;
                        quot_d  = QUOT_FILL;
                        rem_d   = acc_dbz ? dividend[WIDTH-1:0] : REM_FILL;
                    end
`endif
                end
            end

            CALC: begin
                r_d   = step_r;
                q_d   = q_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    // Error operations still iterated (uniform timing) but their
                    // arithmetic is meaningless; override it here.
                    if (dbz_q) begin
                        quot_d = QUOT_FILL;
                        rem_d  = lo_q;
                    end else if (ovf_q) begin
                        quot_d = QUOT_FILL;
                        rem_d  = REM_FILL;
                    end else begin
                        quot_d = q_next;
                        rem_d  = step_r[WIDTH-1:0];
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign err_dbz   = dbz_q;
    assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and constrained-random vectors for seq_divider with hand-derived expectations.
// Latency: checks result latency relative to the accept edge.
// Backpressure: exercises out_ready stalls and ignored in_valid while busy.
module tb_seq_divider;

    localparam int W = 8;
    localparam int LAT_NORMAL = W;   // edges after the accept edge before out_valid is seen
`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_ERR = 0;      // result visible right after the accept edge
`else
    localparam int LAT_ERR = W;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           err_dbz;
    logic           err_ovf;

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err_dbz   (err_dbz),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one operation, then count edges after the accept edge until out_valid.
    task automatic apply(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_release", {31'b0, in_ready}, 32'd1);
        chk("out_valid_after_release", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input logic eovf, input int elat);
        int lat;
        apply(dvd, dvs, lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, {24'b0, quotient}, {24'b0, eq});
        chk({tag, "_r"}, {24'b0, remainder}, {24'b0, er});
        chk({tag, "_dbz"}, {31'b0, err_dbz}, {31'b0, edbz});
        chk({tag, "_ovf"}, {31'b0, err_ovf}, {31'b0, eovf});
        chk({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
        if (!edbz && !eovf) begin
            chk({tag, "_identity"}, 32'(quotient) * 32'(dvs) + 32'(remainder), 32'(dvd));
        end
        release_out();
    endtask

    initial begin
        int lat;
        logic [2*W-1:0] rdvd;
        logic [W-1:0]   rdvs;
        logic [W-1:0]   eq;
        logic [W-1:0]   er;
        logic           edbz;
        logic           eovf;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_quotient", {24'b0, quotient}, 32'd0);
        chk("rst_remainder", {24'b0, remainder}, 32'd0);
        chk("rst_dbz", {31'b0, err_dbz}, 32'd0);
        chk("rst_ovf", {31'b0, err_ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1000 = 142*7 + 6
        run_op("d1000_7", 16'h03E8, 8'h07, 8'd142, 8'd6, 1'b0, 1'b0, LAT_NORMAL);
        // 65025 = 255*255
        run_op("dFE01_FF", 16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, LAT_NORMAL);
        run_op("dbz", 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, LAT_ERR);
        // high half 8 >= 8 -> overflow
        run_op("ovf", 16'h0800, 8'h08, 8'hFF, 8'hFF, 1'b0, 1'b1, LAT_ERR);
        // 2047 = 255*8 + 7, just under the overflow boundary
        run_op("d07FF_8", 16'h07FF, 8'h08, 8'hFF, 8'h07, 1'b0, 1'b0, LAT_NORMAL);
        // Flags from the previous error must clear on the next accept
        run_op("d100_10", 16'd100, 8'd10, 8'd10, 8'd0, 1'b0, 1'b0, LAT_NORMAL);

        // Backpressure: result held, inputs ignored while out_ready is low
        apply(16'h03E8, 8'h07, lat);
        chk("bp_lat", lat, LAT_NORMAL);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            dividend = 16'h1234;
            divisor  = 8'h00;
            @(posedge clk); #1;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_q", {24'b0, quotient}, 32'd142);
            chk("bp_r", {24'b0, remainder}, 32'd6);
            chk("bp_dbz", {31'b0, err_dbz}, 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        run_op("after_bp", 16'h07FF, 8'h08, 8'hFF, 8'h07, 1'b0, 1'b0, LAT_NORMAL);

        // Reset during the fourth CALC step aborts without output
        in_valid = 1'b1;
        dividend = 16'h03E8;
        divisor  = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_quotient", {24'b0, quotient}, 32'd0);
        chk("midrst_remainder", {24'b0, remainder}, 32'd0);
        chk("midrst_dbz", {31'b0, err_dbz}, 32'd0);
        chk("midrst_ovf", {31'b0, err_ovf}, 32'd0);
        run_op("after_rst", 16'h03E8, 8'h07, 8'd142, 8'd6, 1'b0, 1'b0, LAT_NORMAL);

        // Random sweep: half built as q*d+r (no overflow), half unconstrained
        for (int i = 0; i < 160; i++) begin
            if (i % 2 == 0) begin
                rdvs = W'($urandom_range(1, 255));
                eq   = W'($urandom_range(0, 255));
                er   = W'($urandom_range(0, 32'(rdvs) - 1));
                rdvd = 16'(eq) * 16'(rdvs) + 16'(er);
            end else begin
                rdvd = 16'($urandom);
                rdvs = (i % 10 == 1) ? 8'h00 : W'($urandom_range(0, 255));
            end
            if (rdvs == 0) begin
                edbz = 1'b1; eovf = 1'b0; eq = 8'hFF; er = rdvd[7:0];
            end else if (rdvd[15:8] >= rdvs) begin
                edbz = 1'b0; eovf = 1'b1; eq = 8'hFF; er = 8'hFF;
            end else begin
                edbz = 1'b0; eovf = 1'b0;
                eq = W'(rdvd / 16'(rdvs));
                er = W'(rdvd % 16'(rdvs));
            end
            run_op("rnd", rdvd, rdvs, eq, er, edbz, eovf,
                   (edbz || eovf) ? LAT_ERR : LAT_NORMAL);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
